// File: rtl/vga_ctrl_if.sv
// Video bundle between the VGA timing generator, the picture stage and the pins.
// Latency: wires only, no registers.
// Backpressure: none; the video stream is free-running and cannot be stalled.
interface vga_ctrl_if;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        hsync;
    logic        vsync;
    logic        rgb_valid;
    logic [15:0] rgb;
    logic        frame_start;

    // Timing generator side.
    modport master (
        input  pix_data,
        output pix_x, pix_y, hsync, vsync, rgb_valid, rgb, frame_start
    );

    // Picture stage / display side.
    modport slave (
        output pix_data,
        input  pix_x, pix_y, hsync, vsync, rgb_valid, rgb, frame_start
    );
endinterface

// File: rtl/vga_ctrl.sv
// VGA timing generator: h/v counters, syncs, pixel request coordinates and RGB gating.
// Latency: pix_x/pix_y lead rgb_valid by 1 cycle to absorb the picture stage register.
// Backpressure: none; counters free-run, pix_data never affects timing.
module vga_ctrl #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    vga_ctrl_if.master vif
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;

    // Decode bounds sized to the counter width so every compare is 10 bits.
    localparam logic [9:0] C_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] C_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] C_H_SYNC   = 10'(H_SYNC);
    localparam logic [9:0] C_V_SYNC   = 10'(V_SYNC);
    localparam logic [9:0] C_H_ACT_LO = 10'(HA);
    localparam logic [9:0] C_H_ACT_HI = 10'(HA + H_VALID - 1);
    localparam logic [9:0] C_H_REQ_LO = 10'(HA - 1);
    localparam logic [9:0] C_H_REQ_HI = 10'(HA + H_VALID - 2);
    localparam logic [9:0] C_V_ACT_LO = 10'(VA);
    localparam logic [9:0] C_V_ACT_HI = 10'(VA + V_VALID - 1);
    localparam logic [9:0] C_IDLE     = 10'h3FF;

    logic [9:0] r_cnt_h;
    logic [9:0] r_cnt_v;
    logic       r_frame_start;

    logic       w_h_last;
    logic       w_v_last;
    logic       w_v_act;
    logic       w_h_act;
    logic       w_h_req;
    logic       w_pix_req;
    logic       w_rgb_valid;

    assign w_h_last = (r_cnt_h == C_H_LAST);
    assign w_v_last = (r_cnt_v == C_V_LAST);

    // Horizontal counter: free-running, wraps at the end of each line.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt_h <= 10'd0;
        end else if (w_h_last) begin
            r_cnt_h <= 10'd0;
        end else begin
            r_cnt_h <= r_cnt_h + 10'd1;
        end
    end

    // Vertical counter: steps only on the line wrap, so it moves on the same edge as cnt_h wraps.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt_v <= 10'd0;
        end else if (w_h_last) begin
            if (w_v_last) begin
                r_cnt_v <= 10'd0;
            end else begin
                r_cnt_v <= r_cnt_v + 10'd1;
            end
        end
    end

    // Frame marker: registered so it is high exactly while the counters sit at (0,0) after a frame wrap;
    // the (0,0) following reset release never set it, so the first frame after reset has no pulse.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_h_last && w_v_last;
        end
    end

    // Windows decoded from the registered counters only, so syncs and valid are glitch-free per state.
    assign w_v_act     = (r_cnt_v >= C_V_ACT_LO) && (r_cnt_v <= C_V_ACT_HI);
    assign w_h_act     = (r_cnt_h >= C_H_ACT_LO) && (r_cnt_h <= C_H_ACT_HI);
    assign w_h_req     = (r_cnt_h >= C_H_REQ_LO) && (r_cnt_h <= C_H_REQ_HI);
    assign w_pix_req   = w_h_req && w_v_act;
    assign w_rgb_valid = w_h_act && w_v_act;

    assign vif.hsync       = (r_cnt_h >= C_H_SYNC);
    assign vif.vsync       = (r_cnt_v >= C_V_SYNC);
    assign vif.pix_x       = w_pix_req ? (r_cnt_h - C_H_REQ_LO) : C_IDLE;
    assign vif.pix_y       = w_pix_req ? (r_cnt_v - C_V_ACT_LO) : C_IDLE;
    assign vif.rgb_valid   = w_rgb_valid;
    // Gate the pixel so nothing the picture stage drives during blanking reaches the DAC.
    assign vif.rgb         = w_rgb_valid ? vif.pix_data : 16'h0000;
    assign vif.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl with a shrunken timing set so several frames fit in a short run.
// Latency: picture stage model registers {pix_y, pix_x} one cycle, as the real stage does.
// Backpressure: none; monitors sample every falling edge.
module tb_vga_ctrl;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int HV = 8;
    localparam int HF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VV = 4;
    localparam int VF = 1;
    localparam int HT = HS + HB + HV + HF;   // 17
    localparam int VT = VS + VB + VV + VF;   // 9
    localparam int FT = HT * VT;             // 153
    localparam int HA = HS + HB;             // 7
    localparam int VA = VS + VB;             // 4

    logic vga_clk;
    logic sys_rst_n;

    vga_ctrl_if vif ();

    vga_ctrl #(
        .H_SYNC (HS), .H_BACK (HB), .H_VALID (HV), .H_FRONT (HF),
        .V_SYNC (VS), .V_BACK (VB), .V_VALID (VV), .V_FRONT (VF)
    ) dut (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .vif       (vif)
    );

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    // Picture stage: registered, encodes the requested row/column; idle request reads back as 16'hFFFF.
    always @(posedge vga_clk) begin
        vif.pix_data <= {vif.pix_y[5:0], vif.pix_x};
    end

    // Rising edges since reset release: the independent time base for the expected timing.
    int k = 0;
    always @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) k <= 0;
        else            k <= k + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, k=%0d)", name, act, exp, $time, k);
        end
    endtask

    logic [15:0] sb_q[$];

    task automatic push_frame();
        for (int y = 0; y < VV; y++)
            for (int x = 0; x < HV; x++)
                sb_q.push_back({6'(y), 10'(x)});
    endtask

    task automatic wait_k(input int target);
        int guard = 0;
        do begin
            @(negedge vga_clk);
            guard++;
        end while (k != target && guard < 4 * FT);
        if (k != target) check("wait_k_timeout", k, target);
    endtask

    // Scoreboard monitor: every displayed pixel must match the next expected pixel.
    initial begin
        logic [15:0] exp_px;
        forever begin
            @(negedge vga_clk);
            if (sys_rst_n && vif.rgb_valid) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_pixel", 32'(vif.rgb), 32'hDEAD);
                end else begin
                    exp_px = sb_q.pop_front();
                    check("sb_rgb", 32'(vif.rgb), 32'(exp_px));
                end
            end
        end
    end

    // Per-cycle timing monitor computed from k alone, plus event counters for the window checks.
    int hs_low_cnt = 0;
    int vs_low_cnt = 0;
    int rv_cnt     = 0;
    int fs_cnt     = 0;
    int last_fs_k  = -1;

    initial begin
        int h, v;
        logic vact, req, e_rv, e_fs;
        logic [9:0] e_px, e_py;
        forever begin
            @(negedge vga_clk);
            if (!sys_rst_n) begin
                check("reset_outputs",
                      {8'd0, vif.hsync, vif.vsync, vif.rgb_valid, vif.frame_start, vif.pix_x, vif.pix_y},
                      {8'd0, 4'b0000, 10'h3FF, 10'h3FF});
                check("reset_rgb", 32'(vif.rgb), 32'h0);
            end else begin
                h    = k % HT;
                v    = (k / HT) % VT;
                vact = (v >= VA) && (v < VA + VV);
                req  = vact && (h >= HA - 1) && (h <= HA + HV - 2);
                e_rv = vact && (h >= HA) && (h < HA + HV);
                e_fs = (k > 0) && ((k % FT) == 0);
                e_px = req ? 10'(h - (HA - 1)) : 10'h3FF;
                e_py = req ? 10'(v - VA) : 10'h3FF;
                check("timing",
                      {8'd0, vif.hsync, vif.vsync, vif.rgb_valid, vif.frame_start, vif.pix_x, vif.pix_y},
                      {8'd0, (h >= HS), (v >= VS), e_rv, e_fs, e_px, e_py});
                if (!e_rv) check("blank_rgb", 32'(vif.rgb), 32'h0);
                if (!vif.hsync)      hs_low_cnt++;
                if (!vif.vsync)      vs_low_cnt++;
                if (vif.rgb_valid)   rv_cnt++;
                if (vif.frame_start) begin
                    fs_cnt++;
                    last_fs_k = k;
                end
            end
        end
    end

    initial begin
        int s_hs, s_vs, s_rv, s_fs;
        sys_rst_n = 1'b0;
        repeat (3) @(posedge vga_clk);
        #2 sys_rst_n = 1'b1;

        // Two full frames from release.
        s_hs = hs_low_cnt; s_vs = vs_low_cnt; s_rv = rv_cnt; s_fs = fs_cnt;
        push_frame();
        push_frame();
        repeat (2 * FT) @(posedge vga_clk);
        #1;
        check("hsync_low_2fr",    hs_low_cnt - s_hs, 72);   // 2*9 lines * 4
        check("vsync_low_2fr",    vs_low_cnt - s_vs, 68);   // 2 * 2 lines * 17
        check("rgb_valid_2fr",    rv_cnt - s_rv,     64);   // 2 * 4 lines * 8
        check("frame_start_2fr",  fs_cnt - s_fs,     1);
        check("frame_start_at_k", last_fs_k,         FT);
        check("sb_drained_2fr",   sb_q.size(),       0);

        // Mid-frame asynchronous reset at line 5, column 10 of the third frame.
        push_frame();
        wait_k(2 * FT + 5 * HT + 10);
        #1 check("pre_rst_rgb_valid", vif.rgb_valid, 1);
        check("pre_rst_hsync", vif.hsync, 1);
        #1 sys_rst_n = 1'b0;
        #1;
        check("arst_hsync",       vif.hsync,       0);
        check("arst_vsync",       vif.vsync,       0);
        check("arst_rgb_valid",   vif.rgb_valid,   0);
        check("arst_rgb",         32'(vif.rgb),    0);
        check("arst_pix_x",       vif.pix_x,       10'h3FF);
        check("arst_pix_y",       vif.pix_y,       10'h3FF);
        check("arst_frame_start", vif.frame_start, 0);
        sb_q.delete();
        repeat (3) @(posedge vga_clk);
        #2 sys_rst_n = 1'b1;
        s_fs = fs_cnt;
        push_frame();

        // Active-window edges on the first active line.
        wait_k(VA * HT + HA - 1);
        #1 check("lead_pix_x", vif.pix_x, 10'd0);
        check("lead_pix_y",     vif.pix_y,     10'd0);
        check("lead_rgb_valid", vif.rgb_valid, 0);
        wait_k(VA * HT + HA);
        #1 check("first_rgb_valid", vif.rgb_valid, 1);
        check("first_rgb", 32'(vif.rgb), 32'h0000);
        wait_k(VA * HT + HA + HV - 1);
        #1 check("last_pix_x", vif.pix_x, 10'h3FF);
        check("last_rgb_valid", vif.rgb_valid, 1);
        check("last_rgb", 32'(vif.rgb), 32'h0007);
        wait_k(VA * HT + HA + HV);
        #1 check("after_rgb_valid", vif.rgb_valid, 0);
        check("after_rgb", 32'(vif.rgb), 32'h0000);

        // Next frame_start comes exactly one frame period after release.
        wait_k(FT - 1);
        #1 check("fs_before", vif.frame_start, 0);
        wait_k(FT);
        #1 check("fs_at_frame", vif.frame_start, 1);
        check("fs_count_post_rst", fs_cnt - s_fs, 1);
        check("sb_drained_post_rst", sb_q.size(), 0);

        repeat (2) @(posedge vga_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_ctrl.md
VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 Parameter H_SYNC, default 96, hsync pulse width in vga_clk cycles.
REQ-002 Parameter H_BACK, default 48, horizontal back porch in cycles.
REQ-003 Parameter H_VALID, default 640, active pixels per line.
REQ-004 Parameter H_FRONT, default 16, horizontal front porch in cycles.
REQ-005 Parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-006 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-007 Parameter V_VALID, default 480, active lines per frame.
REQ-008 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-009 vga_clk  in  1  pixel clock, 25 MHz nominal; all state on rising edge.
REQ-010 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-011 pix_data  in  16  RGB565 pixel from the picture stage, registered there, 1-cycle latency from pix_x/pix_y.
REQ-012 pix_x  out  10  column request to the picture stage, 0..H_VALID-1, 10'h3FF when idle.
REQ-013 pix_y  out  10  row request to the picture stage, 0..V_VALID-1, 10'h3FF when idle.
REQ-014 hsync  out  1  horizontal sync, active-low.
REQ-015 vsync  out  1  vertical sync, active-low.
REQ-016 rgb_valid  out  1  high while the displayed pixel lies in the active area.
REQ-017 rgb  out  16  RGB565 to DAC/pins; pix_data when rgb_valid, else 16'h0000.
REQ-018 frame_start  out  1  one-cycle pulse at the start of each frame.

Function
REQ-019 H_TOTAL = H_SYNC+H_BACK+H_VALID+H_FRONT (800); V_TOTAL = V_SYNC+V_BACK+V_VALID+V_FRONT (525).
REQ-020 cnt_h, 10-bit register, SHALL increment every cycle and wrap H_TOTAL-1 -> 0.
REQ-021 cnt_v, 10-bit register, SHALL increment only on the cycle cnt_h = H_TOTAL-1 and wrap V_TOTAL-1 -> 0 on the same edge on which cnt_h wraps.
REQ-022 hsync SHALL be 0 for cnt_h in [0, H_SYNC-1] and 1 otherwise, decoded from the registered cnt_h only.
REQ-023 vsync SHALL be 0 for cnt_v in [0, V_SYNC-1] and 1 otherwise, changing only on the cnt_h wrap edge.
REQ-024 Active window: HA = H_SYNC+H_BACK (144), VA = V_SYNC+V_BACK (35); rgb_valid = 1 when cnt_h in [HA, HA+H_VALID-1] and cnt_v in [VA, VA+V_VALID-1].
REQ-025 Request window SHALL lead the active window by exactly 1 cycle: pix_req = 1 when cnt_h in [HA-1, HA+H_VALID-2] and cnt_v in [VA, VA+V_VALID-1].
REQ-026 pix_x = cnt_h-(HA-1) and pix_y = cnt_v-VA while pix_req = 1; both 10'h3FF otherwise.
REQ-027 The 1-cycle lead SHALL cover the picture stage's registered output: pix_data sampled with rgb_valid = 1 corresponds to the pix_x/pix_y of the previous cycle.
REQ-028 rgb SHALL be combinational: rgb_valid ? pix_data : 16'h0000; no blanking-interval leakage.
REQ-029 frame_start, a register, SHALL be 1 for exactly the one cycle in which cnt_h = 0 and cnt_v = 0, set on the wrap edge from (H_TOTAL-1, V_TOTAL-1); 0 at all other times.
REQ-030 Line period SHALL be exactly H_TOTAL cycles; frame period exactly H_TOTAL*V_TOTAL (420000) cycles.
REQ-031 No input other than sys_rst_n SHALL alter counter sequencing; pix_data does not affect timing.

Reset
REQ-032 While sys_rst_n = 0: cnt_h = 0, cnt_v = 0, frame_start = 0, immediately and without waiting for a clock edge.
REQ-033 Outputs during reset by decode: hsync = 0, vsync = 0, rgb_valid = 0, rgb = 0, pix_x = pix_y = 10'h3FF.
REQ-034 Reset asserted mid-frame SHALL abort the frame; after release, counting restarts at (0,0) on the first rising edge, and frame_start does not pulse for that first frame.

Verification
REQ-035 Release reset, run 2 frames -> hsync low 96 of every 800 cycles; vsync low 1600 cycles (2 lines) per 420000; frame_start pulses once, at cycle 420000 after release.
REQ-036 Drive pix_data = {6'd0, pix_x} delayed one cycle -> with rgb_valid = 1, rgb equals displayed column; first active pixel of each line rgb = 0, last = 639; rgb_valid high 640 cycles per line for 480 lines.
REQ-037 At cnt_h = 143, cnt_v = 35 -> pix_x = 0, pix_y = 0, rgb_valid = 0; next cycle rgb_valid = 1; at cnt_h = 783 -> pix_x = 10'h3FF, rgb_valid = 1; at cnt_h = 784 -> rgb_valid = 0.
REQ-038 Hold pix_data = 16'hFFFF constant -> rgb = 16'h0000 whenever rgb_valid = 0, including lines 0-34 and 515-524.
REQ-039 Assert sys_rst_n = 0 at cnt_v = 200, cnt_h = 400 for 3 cycles, between clock edges -> all outputs take reset values asynchronously; after release the next frame_start comes 420000 cycles later.
